// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: synchronises RX_LINE, samples bits at mid-period and
// emits good bytes as single-cycle RX_VALID pulses, framing errors separately.
module uart_rx_frontend #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX_LINE,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_FRAME_ERR,
    output logic       RX_BUSY
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned BIT_IDX_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_START = 3'd1;
    localparam logic [STATE_W-1:0] S_DATA  = 3'd2;
    localparam logic [STATE_W-1:0] S_STOP  = 3'd3;
    localparam logic [STATE_W-1:0] S_BREAK = 3'd4;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic [STATE_W-1:0]   state;
    logic [STATE_W-1:0]   state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [BIT_IDX_W-1:0] bit_idx_nxt;
    logic [7:0]           shift;
    logic [7:0]           shift_nxt;
    logic [7:0]           data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;

    // Two-flop synchroniser; idle level is high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_LINE;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counters and output pulses
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        data_nxt    = RX_DATA;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = S_DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == BIT_IDX_W'(7)) begin
                        state_nxt   = S_STOP;
                        bit_idx_nxt = '0;
                    end else begin
                        bit_idx_nxt = bit_idx + BIT_IDX_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Busy is registered from the next state so it drops with RX_VALID
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            RX_DATA      <= 8'h00;
            RX_VALID     <= 1'b0;
            RX_FRAME_ERR <= 1'b0;
            RX_BUSY      <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            shift        <= shift_nxt;
            RX_DATA      <= data_nxt;
            RX_VALID     <= valid_nxt;
            RX_FRAME_ERR <= ferr_nxt;
            RX_BUSY      <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at 8 and 868 clocks per bit, with a
// byte scoreboard popped on every RX_VALID pulse.
module tb_uart_rx_frontend;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx8;
    logic       rx868;
    logic [7:0] d8;
    logic       v8;
    logic       f8;
    logic       b8;
    logic [7:0] d868;
    logic       v868;
    logic       f868;
    logic       b868;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp8[$];
    logic [7:0] exp868[$];
    int         vt8[$];
    int         vcnt8    = 0;
    int         fcnt8    = 0;
    int         fpend8   = 0;
    int         vcnt868  = 0;
    int         fcnt868  = 0;
    logic [7:0] held8    = 8'h00;
    logic [7:0] held868  = 8'h00;
    logic       pb8      = 1'b0;
    logic       pb868    = 1'b0;
    int         spacing;

    uart_rx_frontend #(.CLKS_PER_BIT(8)) dut8 (
        .clock        (clock),
        .reset        (reset),
        .RX_LINE      (rx8),
        .RX_DATA      (d8),
        .RX_VALID     (v8),
        .RX_FRAME_ERR (f8),
        .RX_BUSY      (b8)
    );

    uart_rx_frontend #(.CLKS_PER_BIT(868)) dut868 (
        .clock        (clock),
        .reset        (reset),
        .RX_LINE      (rx868),
        .RX_DATA      (d868),
        .RX_VALID     (v868),
        .RX_FRAME_ERR (f868),
        .RX_BUSY      (b868)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drives one 8N1 frame, LSB first, each bit held for n cycles
    task automatic send(input bit sel, input logic [7:0] b, input logic stop, input int n);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (sel) rx868 = fr[i];
            else     rx8   = fr[i];
            repeat (n) @(negedge clock);
        end
    endtask

    // Scoreboard and held-data monitor, CLKS_PER_BIT=8 instance
    always @(negedge clock) begin
        if (reset) begin
            held8 = 8'h00;
            pb8   = 1'b0;
        end else begin
            if (v8) begin
                vcnt8++;
                vt8.push_back(cyc);
                chk("v8_expected", 32'(exp8.size() > 0), 32'd1);
                if (exp8.size() > 0) held8 = exp8.pop_front();
                chk("v8_data", 32'(d8), 32'(held8));
                chk("v8_busy_fall", 32'({pb8, b8}), 32'(2'b10));
                chk("v8_no_ferr", 32'(f8), 32'd0);
            end
            if (f8) begin
                fcnt8++;
                chk("f8_expected", 32'(fpend8 > 0), 32'd1);
                if (fpend8 > 0) fpend8--;
            end
            chk("d8_held", 32'(d8), 32'(held8));
            pb8 = b8;
        end
    end

    // Scoreboard for the CLKS_PER_BIT=868 instance
    always @(negedge clock) begin
        if (reset) begin
            held868 = 8'h00;
            pb868   = 1'b0;
        end else begin
            if (v868) begin
                vcnt868++;
                chk("v868_expected", 32'(exp868.size() > 0), 32'd1);
                if (exp868.size() > 0) held868 = exp868.pop_front();
                chk("v868_data", 32'(d868), 32'(held868));
                chk("v868_busy_fall", 32'({pb868, b868}), 32'(2'b10));
            end
            if (f868) begin
                fcnt868++;
            end
            if (v868 || f868) begin
                chk("d868_held", 32'(d868), 32'(held868));
            end
            pb868 = b868;
        end
    end

    initial begin
        rx8   = 1'b1;
        rx868 = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_data", 32'(d8), 32'd0);
        chk("rst_valid", 32'(v8), 32'd0);
        chk("rst_ferr", 32'(f8), 32'd0);
        chk("rst_busy", 32'(b8), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single frame 0x55
        exp8.push_back(8'h55);
        send(1'b0, 8'h55, 1'b1, 8);
        repeat (10) @(negedge clock);
        chk("t1_count", 32'(vcnt8), 32'd1);

        // Back-to-back 0xA3, 0x00
        exp8.push_back(8'hA3);
        exp8.push_back(8'h00);
        send(1'b0, 8'hA3, 1'b1, 8);
        send(1'b0, 8'h00, 1'b1, 8);
        repeat (10) @(negedge clock);
        chk("t2_count", 32'(vcnt8), 32'd3);
        spacing = (vt8.size() >= 3) ? (vt8[2] - vt8[1]) : -1;
        chk("t2_spacing", 32'(spacing), 32'd80);

        // 3-cycle low glitch is rejected
        rx8 = 1'b0;
        repeat (3) @(negedge clock);
        rx8 = 1'b1;
        repeat (20) @(negedge clock);
        chk("t3_busy", 32'(b8), 32'd0);
        chk("t3_count", 32'(vcnt8), 32'd3);
        chk("t3_ferr", 32'(fcnt8), 32'd0);
        chk("t3_data", 32'(d8), 32'h00);

        // Bad stop bit, line held low, then a good frame
        fpend8++;
        send(1'b0, 8'h7E, 1'b0, 8);
        repeat (30) @(negedge clock);
        chk("t4_break_busy", 32'(b8), 32'd1);
        rx8 = 1'b1;
        repeat (10) @(negedge clock);
        chk("t4_ferr_count", 32'(fcnt8), 32'd1);
        chk("t4_data_held", 32'(d8), 32'h00);
        chk("t4_idle", 32'(b8), 32'd0);
        exp8.push_back(8'h41);
        send(1'b0, 8'h41, 1'b1, 8);
        repeat (10) @(negedge clock);
        chk("t4_count", 32'(vcnt8), 32'd4);
        chk("t4_data", 32'(d8), 32'h41);

        // Reset during data bit 4 of 0xFF
        rx8 = 1'b0;
        repeat (8) @(negedge clock);
        rx8 = 1'b1;
        repeat (36) @(negedge clock);
        chk("t5_busy_mid", 32'(b8), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_data", 32'(d8), 32'd0);
        chk("t5_rst_valid", 32'(v8), 32'd0);
        chk("t5_rst_ferr", 32'(f8), 32'd0);
        chk("t5_rst_busy", 32'(b8), 32'd0);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("t5_no_pulse", 32'(vcnt8), 32'd4);
        chk("t5_idle", 32'(b8), 32'd0);
        exp8.push_back(8'h12);
        send(1'b0, 8'h12, 1'b1, 8);
        repeat (10) @(negedge clock);
        chk("t5_count", 32'(vcnt8), 32'd5);
        chk("t5_data", 32'(d8), 32'h12);

        // 868 clocks per bit, 2% fast and 2% slow senders
        exp868.push_back(8'hC9);
        send(1'b1, 8'hC9, 1'b1, 851);
        repeat (500) @(negedge clock);
        chk("t6_fast_count", 32'(vcnt868), 32'd1);
        chk("t6_fast_data", 32'(d868), 32'hC9);
        exp868.push_back(8'hC9);
        send(1'b1, 8'hC9, 1'b1, 885);
        repeat (500) @(negedge clock);
        chk("t6_slow_count", 32'(vcnt868), 32'd2);
        chk("t6_slow_data", 32'(d868), 32'hC9);
        chk("t6_no_ferr", 32'(fcnt868), 32'd0);

        repeat (20) @(negedge clock);
        chk("end_exp8_empty", 32'(exp8.size()), 32'd0);
        chk("end_exp868_empty", 32'(exp868.size()), 32'd0);
        chk("end_ferr8_total", 32'(fcnt8), 32'd1);
        chk("end_busy868", 32'(b868), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
